// File: rtl/debounce_multi.sv
// Multi-channel pushbutton conditioner: two-flop synchroniser, stable-count debounce,
// toggle with synchronous clear, press/release pulses and a one-shot long-press pulse.
`timescale 1ns/1ps
module debounce_multi #(
    parameter int unsigned N_CH       = 4,
    parameter int unsigned STABLE_CNT = 4,
    parameter int unsigned LONG_CNT   = 1000
) (
    input  logic            clk_1kHz,
    input  logic            rst,
    input  logic [N_CH-1:0] btn_raw,
    input  logic [N_CH-1:0] toggle_clr,
    output logic [N_CH-1:0] btn_level,
    output logic [N_CH-1:0] btn_toggle,
    output logic [N_CH-1:0] press_pulse,
    output logic [N_CH-1:0] release_pulse,
    output logic [N_CH-1:0] long_press
);

    localparam int unsigned DW = $clog2(STABLE_CNT + 1);
    localparam logic [DW-1:0] DLast = DW'(STABLE_CNT - 1);
    localparam logic [15:0] HLong = 16'(LONG_CNT);
    localparam logic [15:0] HArm  = 16'(LONG_CNT - 1);

    logic [N_CH-1:0] sync1_q, sync2_q;
    logic [N_CH-1:0] level_q, level_d;
    logic [N_CH-1:0] toggle_q, toggle_d;
    logic [N_CH-1:0] press_q, press_d;
    logic [N_CH-1:0] rel_q, rel_d;
    logic [N_CH-1:0] long_q, long_d;
    logic [DW-1:0]   dcnt_q [N_CH];
    logic [DW-1:0]   dcnt_d [N_CH];
    logic [15:0]     hcnt_q [N_CH];
    logic [15:0]     hcnt_d [N_CH];

    always_comb begin
        level_d  = level_q;
        press_d  = '0;
        rel_d    = '0;
        toggle_d = toggle_q;
        long_d   = '0;
        for (int i = 0; i < int'(N_CH); i++) begin
            dcnt_d[i] = '0;
            hcnt_d[i] = '0;
            // Any sample matching the current level restarts the stability count.
            if (sync2_q[i] != level_q[i]) begin
                if (dcnt_q[i] == DLast) begin
                    level_d[i] = sync2_q[i];
                end else begin
                    dcnt_d[i] = dcnt_q[i] + DW'(1);
                end
            end
            press_d[i]  = level_d[i] & ~level_q[i];
            rel_d[i]    = ~level_d[i] & level_q[i];
            toggle_d[i] = toggle_clr[i] ? 1'b0 : (toggle_q[i] ^ press_d[i]);
            // The rising edge itself is hold cycle 1; saturation prevents a second pulse.
            if (level_d[i]) begin
                hcnt_d[i] = (hcnt_q[i] == HLong) ? hcnt_q[i] : hcnt_q[i] + 16'd1;
                long_d[i] = (hcnt_q[i] == HArm);
            end
        end
    end

    always_ff @(posedge clk_1kHz or posedge rst) begin
        if (rst) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            level_q  <= '0;
            toggle_q <= '0;
            press_q  <= '0;
            rel_q    <= '0;
            long_q   <= '0;
            for (int i = 0; i < int'(N_CH); i++) begin
                dcnt_q[i] <= '0;
                hcnt_q[i] <= '0;
            end
        end else begin
            sync1_q  <= btn_raw;
            sync2_q  <= sync1_q;
            level_q  <= level_d;
            toggle_q <= toggle_d;
            press_q  <= press_d;
            rel_q    <= rel_d;
            long_q   <= long_d;
            for (int i = 0; i < int'(N_CH); i++) begin
                dcnt_q[i] <= dcnt_d[i];
                hcnt_q[i] <= hcnt_d[i];
            end
        end
    end

    assign btn_level     = level_q;
    assign btn_toggle    = toggle_q;
    assign press_pulse   = press_q;
    assign release_pulse = rel_q;
    assign long_press    = long_q;

endmodule

// File: tb/tb_debounce_multi.sv
// Bench for debounce_multi: directed scenarios plus random stimulus, all checked against
// a sample-history reference model of the debounce/toggle/long-press rules.
`timescale 1ns/1ps
module tb_debounce_multi;

    localparam int N = 4;
    localparam int S = 4;
    localparam int L = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] btn_raw;
    logic [3:0] toggle_clr;
    logic [3:0] btn_level, btn_toggle, press_pulse, release_pulse, long_press;
    logic [19:0] act;

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [3:0] d1, d2, m_lvl, m_tog, m_pp, m_rp, m_lp;
    logic       hist [N][S];
    int         held [N];

    debounce_multi #(.N_CH(N), .STABLE_CNT(S), .LONG_CNT(L)) dut (
        .clk_1kHz     (clk),
        .rst          (rst),
        .btn_raw      (btn_raw),
        .toggle_clr   (toggle_clr),
        .btn_level    (btn_level),
        .btn_toggle   (btn_toggle),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse),
        .long_press   (long_press)
    );

    always #500 clk = ~clk;

    assign act = {btn_level, btn_toggle, press_pulse, release_pulse, long_press};

    function automatic logic [19:0] exp_vec();
        return {m_lvl, m_tog, m_pp, m_rp, m_lp};
    endfunction

    task automatic model_reset();
        d1 = '0; d2 = '0; m_lvl = '0; m_tog = '0; m_pp = '0; m_rp = '0; m_lp = '0;
        for (int c = 0; c < N; c++) begin
            held[c] = 0;
            for (int k = 0; k < S; k++) hist[c][k] = 1'b0;
        end
    endtask

    // Level follows the synchronised input once the last S samples all agree on a new value.
    task automatic tick();
        logic [3:0] raw_s, clr_s;
        logic       smp, old, same;
        raw_s = btn_raw;
        clr_s = toggle_clr;
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            for (int c = 0; c < N; c++) begin
                smp = d2[c];
                for (int k = S - 1; k > 0; k--) hist[c][k] = hist[c][k-1];
                hist[c][0] = smp;
                same = 1'b1;
                for (int k = 0; k < S; k++) if (hist[c][k] != smp) same = 1'b0;
                old = m_lvl[c];
                if (same && smp != old) m_lvl[c] = smp;
                m_pp[c]  = m_lvl[c] & ~old;
                m_rp[c]  = ~m_lvl[c] & old;
                m_tog[c] = clr_s[c] ? 1'b0 : (m_tog[c] ^ m_pp[c]);
                held[c]  = m_lvl[c] ? held[c] + 1 : 0;
                m_lp[c]  = m_lvl[c] && (held[c] == L);
            end
            d2 = d1;
            d1 = raw_s;
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; btn_raw = 4'hF; toggle_clr = 4'h0;
        model_reset();
        #1200;
        total++;
        if (act !== 20'h0) begin
            bad++; $display("FAIL reset_hold1 got=%h exp=%h", act, 20'h0);
        end
        #1000;
        total++;
        if (act !== 20'h0) begin
            bad++; $display("FAIL reset_hold2 got=%h exp=%h", act, 20'h0);
        end
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            total++;
            if (act !== exp_vec()) begin
                bad++; $display("FAIL reset_seq i=%0d got=%h exp=%h", i, act, exp_vec());
            end
            if (i == 4) begin
                total++;
                if (btn_level !== 4'h0) begin
                    bad++; $display("FAIL reset_early_level got=%h exp=0", btn_level);
                end
            end
            if (i == 5) begin
                total++;
                if ({btn_level, press_pulse, btn_toggle} !== 12'hFFF) begin
                    bad++; $display("FAIL reset_first_press got=%h exp=fff",
                                    {btn_level, press_pulse, btn_toggle});
                end
            end
        end
    endtask

    task automatic test_bounce();
        int n, presses;
        btn_raw = 4'h0; toggle_clr = 4'hF;
        tick();
        toggle_clr = 4'h0;
        for (int i = 0; i < 10; i++) begin
            tick();
            total++;
            if (act !== exp_vec()) begin
                bad++; $display("FAIL bounce_settle i=%0d got=%h exp=%h", i, act, exp_vec());
            end
        end
        n = $urandom_range(2, 4);
        for (int i = 0; i < 2 * n; i++) begin
            btn_raw[0] = (i % 2 == 0);
            btn_raw[1] = (i < 3);
            tick();
            total++;
            if (act !== exp_vec() || btn_level[1] !== 1'b0) begin
                bad++; $display("FAIL bounce_chatter i=%0d got=%h exp=%h", i, act, exp_vec());
            end
        end
        btn_raw[0] = 1'b1; btn_raw[1] = 1'b0;
        presses = 0;
        for (int i = 0; i < 9; i++) begin
            tick();
            presses += int'(press_pulse[0]);
            total++;
            if (act !== exp_vec() || btn_level[1] !== 1'b0) begin
                bad++; $display("FAIL bounce_hold i=%0d got=%h exp=%h", i, act, exp_vec());
            end
            if (i == 4) begin
                total++;
                if (btn_level[0] !== 1'b0) begin
                    bad++; $display("FAIL bounce_early got=%b exp=0", btn_level[0]);
                end
            end
            if (i == 5) begin
                total++;
                if ({btn_level[0], press_pulse[0], btn_toggle[0]} !== 3'b111) begin
                    bad++; $display("FAIL bounce_rise got=%b exp=111",
                                    {btn_level[0], press_pulse[0], btn_toggle[0]});
                end
            end
        end
        total++;
        if (presses != 1) begin
            bad++; $display("FAIL bounce_pulse_count got=%0d exp=1", presses);
        end
    endtask

    task automatic test_toggle();
        int pp, rp;
        logic [1:0] tog_seen;
        btn_raw = 4'h0;
        for (int i = 0; i < 10; i++) tick();
        pp = 0; rp = 0;
        for (int p = 0; p < 2; p++) begin
            for (int ph = 0; ph < 2; ph++) begin
                btn_raw[2] = (ph == 0);
                for (int i = 0; i < 10; i++) begin
                    tick();
                    pp += int'(press_pulse[2]);
                    rp += int'(release_pulse[2]);
                    total++;
                    if (act !== exp_vec()) begin
                        bad++; $display("FAIL toggle_seq p=%0d i=%0d got=%h exp=%h",
                                        p, i, act, exp_vec());
                    end
                end
                if (ph == 0) tog_seen[p] = btn_toggle[2];
            end
        end
        total++;
        if (pp != 2 || rp != 2 || tog_seen !== 2'b01) begin
            bad++; $display("FAIL toggle_counts got=%0d/%0d/%b exp=2/2/01", pp, rp, tog_seen);
        end
        btn_raw[2] = 1'b1;
        for (int i = 0; i < 9; i++) begin
            toggle_clr[2] = (i == 5);
            tick();
            total++;
            if (act !== exp_vec()) begin
                bad++; $display("FAIL toggle_clr_seq i=%0d got=%h exp=%h", i, act, exp_vec());
            end
            if (i == 5) begin
                total++;
                if ({press_pulse[2], btn_toggle[2]} !== 2'b10) begin
                    bad++; $display("FAIL toggle_clr_prio got=%b exp=10",
                                    {press_pulse[2], btn_toggle[2]});
                end
            end
        end
        toggle_clr = 4'h0;
        btn_raw[2] = 1'b0;
        for (int i = 0; i < 8; i++) tick();
    endtask

    task automatic test_long();
        int lc, pulses, at;
        for (int r = 0; r < 2; r++) begin
            btn_raw[3] = 1'b1;
            lc = 0; pulses = 0; at = -1;
            for (int i = 0; i < 5 + L + 12; i++) begin
                tick();
                if (btn_level[3]) lc++;
                if (long_press[3]) begin
                    pulses++;
                    at = lc;
                end
                total++;
                if (act !== exp_vec()) begin
                    bad++; $display("FAIL long_seq r=%0d i=%0d got=%h exp=%h",
                                    r, i, act, exp_vec());
                end
            end
            total++;
            if (pulses != 1 || at != L) begin
                bad++; $display("FAIL long_once r=%0d got=%0d@%0d exp=1@%0d", r, pulses, at, L);
            end
            btn_raw[3] = 1'b0;
            for (int i = 0; i < 10; i++) tick();
        end
    endtask

    task automatic test_simultaneous();
        btn_raw = 4'b0010;
        for (int i = 0; i < 16; i++) tick();
        btn_raw = 4'b0001;
        for (int i = 0; i < 8; i++) begin
            tick();
            total++;
            if (act !== exp_vec()) begin
                bad++; $display("FAIL simul_seq i=%0d got=%h exp=%h", i, act, exp_vec());
            end
            if (i == 5) begin
                total++;
                if ({btn_level, press_pulse, release_pulse} !== 12'b0001_0001_0010) begin
                    bad++; $display("FAIL simul_edge got=%b exp=000100010010",
                                    {btn_level, press_pulse, release_pulse});
                end
            end
        end
        btn_raw = 4'h0;
        for (int i = 0; i < 16; i++) tick();
    endtask

    task automatic test_mid_reset();
        int guard, lc, pulses, at;
        btn_raw[3] = 1'b1;
        guard = 0;
        while (held[3] != 5 && guard < 30) begin
            tick();
            guard++;
        end
        total++;
        if (held[3] != 5) begin
            bad++; $display("FAIL midreset_reach got=%0d exp=5", held[3]);
        end
        #300;
        rst = 1'b1;
        model_reset();
        #1;
        total++;
        if (act !== 20'h0) begin
            bad++; $display("FAIL midreset_async got=%h exp=%h", act, 20'h0);
        end
        #200;
        rst = 1'b0;
        lc = 0; pulses = 0; at = -1;
        for (int i = 0; i < 5 + L + 6; i++) begin
            tick();
            if (btn_level[3]) lc++;
            if (long_press[3]) begin
                pulses++;
                at = lc;
            end
            total++;
            if (act !== exp_vec()) begin
                bad++; $display("FAIL midreset_seq i=%0d got=%h exp=%h", i, act, exp_vec());
            end
        end
        total++;
        if (pulses != 1 || at != L) begin
            bad++; $display("FAIL midreset_long got=%0d@%0d exp=1@%0d", pulses, at, L);
        end
        btn_raw[3] = 1'b0;
        for (int i = 0; i < 10; i++) tick();
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            for (int c = 0; c < N; c++) begin
                if ($urandom_range(0, 5) == 0) btn_raw[c] = ~btn_raw[c];
                toggle_clr[c] = ($urandom_range(0, 15) == 0);
            end
            tick();
            total++;
            if (act !== exp_vec()) begin
                bad++; $display("FAIL random i=%0d got=%h exp=%h", i, act, exp_vec());
            end
        end
        toggle_clr = 4'h0;
    endtask

    initial begin
        test_reset();
        test_bounce();
        test_toggle();
        test_long();
        test_simultaneous();
        test_mid_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
